arrow_scheduler: RTL and testbench
==================================

# arrow_scheduler

Per-frame controller for the arrow lanes of the DDR playfield. It spawns arrows from a fixed step pattern on a beat. It scrolls each active arrow upward toward the target zone once per video frame, and judges button presses as hits or misses. It drives the packed per-lane Y bus that the arrow renderer consumes, plus hit/miss pulses and a score for the HUD.

## Interface
- CORDW, 10: screen coordinate width.
- ARROW_COUNT, 4: number of lanes.
- SPAWN_Y, 470: Y loaded into a lane at spawn.
- TARGET_Y, 40: Y of the target zone; must satisfy TARGET_Y ≥ HIT_WIN.
- HIT_WIN, 8: hit window, ± pixels around TARGET_Y.
- SPEED, 2: pixels an arrow moves up per frame.
- BEAT_FRAMES, 30: frames per beat (spawn interval).
- PATTERN_LEN, 16: entries in the step pattern.
- SCOREW, 8: score width.
- clk_i  in  1  pixel clock. One clock only.
- rst_ni  in  1  reset, asynchronous and active-low.
- frame_i  in  1  one-cycle pulse at start of vertical blank.
- run_i  in  1  game running; when low, frame_i is ignored and all state freezes.
- btn_i  in  ARROW_COUNT  debounced, synchronized lane buttons, active-high; bit ARROW_COUNT-1 is lane 1.
- arrow_y_o  out  CORDW*ARROW_COUNT  packed Y; lane 1 in MSBs, lane 4 in bits [CORDW-1:0].
- arrow_active_o  out  ARROW_COUNT  lane holds a live arrow; same bit order as btn_i.
- hit_o  out  1  one-cycle pulse per judged hit.
- miss_o  out  1  one-cycle pulse per missed arrow.
- score_o  out  SCOREW  hit count, saturating.
- busy_o  out  1  frame update in progress.

## Operation
- Reset values: arrow_y_o all lanes OFFSCREEN_Y = all-ones (1023); arrow_active_o 0; hit_o, miss_o and busy_o 0; score_o 0. Beat counter, pattern index and pending presses are cleared. FSM is in IDLE.
- Press capture: a rising edge on btn_i[n] sets pending[n]. The edge register runs every cycle, including while run_i is low. pending[n] is cleared at the end of lane n's UPDATE slot.
- FSM states: IDLE → UPD (lane index 0..ARROW_COUNT-1, one cycle per lane) → SPAWN → IDLE.
  - Leave IDLE on frame_i && run_i.
  - frame_i outside IDLE is ignored.
- UPD lane n, using the pre-move y. Evaluation is in priority order:
  1. If active, pending[n] (or an edge in this same cycle), and |y − TARGET_Y| ≤ HIT_WIN: hit. Lane goes inactive, y = OFFSCREEN_Y, hit_o pulses, score saturating +1.
  2. Else if active and y − SPEED < TARGET_Y − HIT_WIN: miss. Lane goes inactive, y = OFFSCREEN_Y, miss_o pulses.
  3. Else if active: y = y − SPEED.
  4. A press on an inactive lane, or outside the window, is discarded with no penalty.
- Arithmetic: compute comparisons in CORDW+1 bits so y − SPEED cannot wrap. Use the absolute difference for the window test.
- SPAWN:
  - Beat counter increments each run frame. At BEAT_FRAMES−1 it wraps to 0 and marks a beat.
  - On a beat: every lane whose pattern bit is 1 and that is currently inactive is loaded with y = SPAWN_Y and goes active. Lanes that are already active are left unchanged; that spawn is dropped.
  - On a beat, the pattern index increments and wraps from PATTERN_LEN−1 to 0.
- Inactive lanes always output OFFSCREEN_Y, so the renderer never draws them.
- Reset asserted mid-frame returns everything to reset values immediately. No partial update survives.

## Timing
- frame_i sampled at cycle 0.
- busy_o is high in cycles 1..ARROW_COUNT+1.
- Lane n is updated in cycle n+1; SPAWN runs in cycle ARROW_COUNT+1.
- All outputs are registered. Lane n's y, active, hit_o and miss_o change at the clock edge ending its slot and are visible from cycle n+2.
- Hits and misses in different lanes in the same frame produce separate pulses in distinct cycles.
- With defaults, all outputs are stable from cycle 6 until the next frame_i. This is well inside vertical blank.

## Structure
- Shared package ddr_pkg holds:
  - the ctrl_state_e enum (IDLE, UPD, SPAWN);
  - OFFSCREEN_Y;
  - the default timing constants, shared with the renderer instance.
- Sub-module arrow_pattern_rom: combinational lookup from index to ARROW_COUNT-bit step mask, PATTERN_LEN entries. Entry 0 = 4'b1000, entry 1 = 4'b0100, entry 2 = 4'b0010, entry 3 = 4'b0001, then repeats.
- Estimated 200–300 lines of RTL.

## Test plan
- Reset: rst_ni low then high → arrow_y_o = {4{10'd1023}}, arrow_active_o = 0, score_o = 0, busy_o = 0.
- Spawn: run_i = 1, 30 frame_i pulses → after the 30th frame's SPAWN, lane 1 has y = 470 and arrow_active_o = 4'b1000. The 60th frame spawns lane 2.
- Scroll: after spawn, one more frame → lane 1 y = 468. After 215 frames → y = 40.
- Hit: press lane 1 when y = 44 → hit_o pulses once, score_o = 1, lane 1 y = 1023, inactive. A press at y = 60 → no hit, and the arrow keeps moving.
- Miss: no press. At y = 34 the lane moves to 32. In the next frame (32 − 2 < 32) → miss_o pulses, y = 1023, score unchanged.
- Boundaries:
  - pattern bit set on an already-active lane → y unchanged, no respawn;
  - frame_i while busy_o = 1 → ignored;
  - rst_ni low during cycle 3 of an update → all outputs at reset values immediately;
  - score at 255 plus a hit → stays 255.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and default geometry/timing for the DDR playfield arrow path.
// The arrow renderer and arrow_scheduler both take their defaults from here.
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPD,
    SPAWN
  } ctrl_state_e;

  localparam int DEF_CORDW       = 10;
  localparam int DEF_ARROW_COUNT = 4;
  localparam int DEF_SPAWN_Y     = 470;
  localparam int DEF_TARGET_Y    = 40;
  localparam int DEF_HIT_WIN     = 8;
  localparam int DEF_SPEED       = 2;
  localparam int DEF_BEAT_FRAMES = 30;
  localparam int DEF_PATTERN_LEN = 16;
  localparam int DEF_SCOREW      = 8;

  // All-ones Y parks a lane below the visible area so the renderer skips it.
  localparam logic [DEF_CORDW-1:0] OFFSCREEN_Y = '1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arrow_pattern_rom.sv
// Step-pattern lookup: index -> one-hot lane mask, walking lane 1 (MSB) down to the LSB lane.
// Purely combinational; indices at or beyond PATTERN_LEN return an empty mask.
module arrow_pattern_rom #(
  parameter int ARROW_COUNT = 4,
  parameter int PATTERN_LEN = 16,
  parameter int IDXW        = 4
) (
  input  logic [IDXW-1:0]        idx_i,
  output logic [ARROW_COUNT-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < PATTERN_LEN; i++) begin
      if (idx_i == IDXW'(i)) begin
        mask_o[ARROW_COUNT-1-(i % ARROW_COUNT)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Per-frame arrow lane controller: one UPD cycle per lane, then a SPAWN cycle, all registered.
// No backpressure: frame_i is taken only in IDLE with run_i high; run_i low freezes the frame FSM.
module arrow_scheduler
  import ddr_pkg::*;
#(
  parameter int CORDW       = DEF_CORDW,
  parameter int ARROW_COUNT = DEF_ARROW_COUNT,
  parameter int SPAWN_Y     = DEF_SPAWN_Y,
  parameter int TARGET_Y    = DEF_TARGET_Y,
  parameter int HIT_WIN     = DEF_HIT_WIN,
  parameter int SPEED       = DEF_SPEED,
  parameter int BEAT_FRAMES = DEF_BEAT_FRAMES,
  parameter int PATTERN_LEN = DEF_PATTERN_LEN,
  parameter int SCOREW      = DEF_SCOREW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         frame_i,
  input  logic                         run_i,
  input  logic [ARROW_COUNT-1:0]       btn_i,
  output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
  output logic [ARROW_COUNT-1:0]       arrow_active_o,
  output logic                         hit_o,
  output logic                         miss_o,
  output logic [SCOREW-1:0]            score_o,
  output logic                         busy_o
);

  localparam int LANEW = clog2_min1(ARROW_COUNT);
  localparam int BEATW = clog2_min1(BEAT_FRAMES);
  localparam int IDXW  = clog2_min1(PATTERN_LEN);

  localparam logic [CORDW-1:0] OFF_Y   = {CORDW{1'b1}};
  localparam logic [CORDW:0]   TGT_Y   = (CORDW+1)'(TARGET_Y);
  localparam logic [CORDW:0]   WIN     = (CORDW+1)'(HIT_WIN);
  // y - SPEED < TARGET_Y - HIT_WIN rearranged so nothing can go negative.
  localparam logic [CORDW:0]   MISS_LT = (CORDW+1)'(TARGET_Y - HIT_WIN + SPEED);

  ctrl_state_e                  state_q, state_d;
  logic [LANEW-1:0]             lane_q, lane_d;
  logic [BEATW-1:0]             beat_q, beat_d;
  logic [IDXW-1:0]              pat_q, pat_d;
  logic [ARROW_COUNT-1:0]       btn_q, btn_d;
  logic [ARROW_COUNT-1:0]       pend_q, pend_d;
  logic [CORDW*ARROW_COUNT-1:0] y_q, y_d;
  logic [ARROW_COUNT-1:0]       act_q, act_d;
  logic                         hit_q, hit_d;
  logic                         miss_q, miss_d;
  logic [SCOREW-1:0]            score_q, score_d;
  logic                         busy_q, busy_d;

  logic [ARROW_COUNT-1:0] btn_rise;
  logic [ARROW_COUNT-1:0] spawn_mask;
  logic [CORDW:0]         cur_y;
  logic [CORDW:0]         diff;
  logic                   pressed;
  int                     lane_base;

  assign btn_rise = btn_i & ~btn_q;

  arrow_pattern_rom #(
    .ARROW_COUNT(ARROW_COUNT),
    .PATTERN_LEN(PATTERN_LEN),
    .IDXW       (IDXW)
  ) u_pattern_rom (
    .idx_i (pat_q),
    .mask_o(spawn_mask)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    beat_d    = beat_q;
    pat_d     = pat_q;
    btn_d     = btn_i;
    pend_d    = pend_q | btn_rise;
    y_d       = y_q;
    act_d     = act_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    score_d   = score_q;
    lane_base = int'(lane_q) * CORDW;
    cur_y     = {1'b0, y_q[lane_base +: CORDW]};
    diff      = (cur_y >= TGT_Y) ? (cur_y - TGT_Y) : (TGT_Y - cur_y);
    pressed   = pend_q[lane_q] | btn_rise[lane_q];

    if (run_i) begin
      case (state_q)
        IDLE: begin
          if (frame_i) begin
            state_d = UPD;
            lane_d  = '0;
          end
        end
        UPD: begin
          if (act_q[lane_q]) begin
            if (pressed && (diff <= WIN)) begin
              act_d[lane_q]             = 1'b0;
              y_d[lane_base +: CORDW]   = OFF_Y;
              hit_d                     = 1'b1;
              if (~&score_q) score_d    = score_q + SCOREW'(1);
            end else if (cur_y < MISS_LT) begin
              act_d[lane_q]             = 1'b0;
              y_d[lane_base +: CORDW]   = OFF_Y;
              miss_d                    = 1'b1;
            end else begin
              y_d[lane_base +: CORDW]   = cur_y[CORDW-1:0] - CORDW'(SPEED);
            end
          end
          // A press is only good for the lane's slot it lands in or precedes.
          pend_d[lane_q] = 1'b0;
          if (lane_q == LANEW'(ARROW_COUNT-1)) begin
            state_d = SPAWN;
          end else begin
            lane_d = lane_q + LANEW'(1);
          end
        end
        SPAWN: begin
          if (beat_q == BEATW'(BEAT_FRAMES-1)) begin
            beat_d = '0;
            for (int i = 0; i < ARROW_COUNT; i++) begin
              if (spawn_mask[i] && !act_q[i]) begin
                act_d[i]               = 1'b1;
                y_d[i*CORDW +: CORDW]  = CORDW'(SPAWN_Y);
              end
            end
            pat_d = (pat_q == IDXW'(PATTERN_LEN-1)) ? '0 : pat_q + IDXW'(1);
          end else begin
            beat_d = beat_q + BEATW'(1);
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lane_q  <= '0;
      beat_q  <= '0;
      pat_q   <= '0;
      btn_q   <= '0;
      pend_q  <= '0;
      y_q     <= '1;
      act_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      pat_q   <= pat_d;
      btn_q   <= btn_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      act_q   <= act_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      busy_q  <= busy_d;
    end
  end

  assign arrow_y_o      = y_q;
  assign arrow_active_o = act_q;
  assign hit_o          = hit_q;
  assign miss_o         = miss_q;
  assign score_o        = score_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Bench for arrow_scheduler: directed frame table, hand-written busy/reset sequences,
// then random presses and run gating checked against a per-frame game model.
module tb_arrow_scheduler;

  localparam int TGT   = 40;
  localparam int WIN   = 8;
  localparam int SPD   = 2;
  localparam int BEAT  = 30;
  localparam int PLEN  = 16;
  localparam int SPAWN = 470;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        frame_i = 1'b0;
  logic        run_i   = 1'b0;
  logic [3:0]  btn_i   = 4'b0000;
  logic [39:0] arrow_y_o, y_s;
  logic [3:0]  arrow_active_o, act_s;
  logic        hit_o, miss_o, busy_o, hit_s, miss_s, busy_s;
  logic [7:0]  score_o;
  logic [3:0]  score_s;

  arrow_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_i(frame_i), .run_i(run_i), .btn_i(btn_i),
    .arrow_y_o(arrow_y_o), .arrow_active_o(arrow_active_o), .hit_o(hit_o),
    .miss_o(miss_o), .score_o(score_o), .busy_o(busy_o)
  );

  // Narrow-score twin sharing all inputs, so saturation is reachable in a short run.
  arrow_scheduler #(.SCOREW(4)) dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .frame_i(frame_i), .run_i(run_i), .btn_i(btn_i),
    .arrow_y_o(y_s), .arrow_active_o(act_s), .hit_o(hit_s),
    .miss_o(miss_s), .score_o(score_s), .busy_o(busy_s)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;
  int hit_cnt = 0, miss_cnt = 0, hit_cnt_s = 0, miss_cnt_s = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (hit_o) hit_cnt++;
    if (miss_o) miss_cnt++;
    if (hit_s) hit_cnt_s++;
    if (miss_s) miss_cnt_s++;
    if (hit_o || miss_o) begin
      checks++;
      if (hit_o && miss_o) begin
        fails++;
        $display("FAIL pulse_overlap: hit_o=%0b miss_o=%0b expected at most one", hit_o, miss_o);
      end
    end
  end

  // ---------------- reference model: whole-frame game rules ----------------
  int         m_y[4];
  bit         m_act[4];
  int         m_beat, m_pat, m_hits, m_misses;
  logic [3:0] prev_btn = 4'b0000;
  logic [3:0] acc      = 4'b0000;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin m_act[b] = 0; m_y[b] = 1023; end
    m_beat = 0; m_pat = 0; m_hits = 0; m_misses = 0;
    acc = 4'b0000; prev_btn = btn_i;
  endtask

  task automatic model_frame(input logic [3:0] press);
    int lb;
    for (int b = 0; b < 4; b++) begin
      if (m_act[b]) begin
        int d;
        d = m_y[b] - TGT;
        if (d < 0) d = -d;
        if (press[b] && d <= WIN) begin m_act[b] = 0; m_hits++; end
        else if (m_y[b] - SPD < TGT - WIN) begin m_act[b] = 0; m_misses++; end
        else m_y[b] = m_y[b] - SPD;
      end
    end
    m_beat++;
    if (m_beat == BEAT) begin
      m_beat = 0;
      lb = 3 - (m_pat % 4);
      if (!m_act[lb]) begin m_act[lb] = 1; m_y[lb] = SPAWN; end
      m_pat = (m_pat + 1) % PLEN;
    end
  endtask

  function automatic logic [39:0] m_bus();
    logic [39:0] r;
    for (int b = 0; b < 4; b++) r[b*10 +: 10] = m_act[b] ? 10'(m_y[b]) : 10'h3FF;
    return r;
  endfunction

  function automatic logic [3:0] m_actv();
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = m_act[b];
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_y"},      arrow_y_o,      m_bus());
    chk({tag, "_act"},    arrow_active_o, m_actv());
    chk({tag, "_score"},  score_o,        sat(m_hits, 255));
    chk({tag, "_score4"}, score_s,        sat(m_hits, 15));
    chk({tag, "_busy"},   busy_o,         1'b0);
    chk({tag, "_y4"},     y_s,            m_bus());
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_frame(input logic [3:0] b, input logic r);
    acc      = acc | (b & ~prev_btn);
    prev_btn = b;
    btn_i    = b;
    run_i    = r;
    frame_i  = 1'b1;
    step();
    frame_i  = 1'b0;
    repeat (5) step();
    if (r) begin
      model_frame(acc);
      acc = 4'b0000;
    end
  endtask

  typedef struct {
    logic [3:0]  btn;
    int          frames;
    logic [39:0] exp_y;
    logic [3:0]  exp_act;
    int          exp_score;
    int          exp_hits;
    int          exp_miss;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    // Lane 1 occupies bits [39:30], lane 4 bits [9:0].
    tbl[0] = '{4'b0000, 29,  {4{10'd1023}},                           4'b0000, 0, 0, 0};
    tbl[1] = '{4'b0000, 1,   {10'd470, {3{10'd1023}}},                4'b1000, 0, 0, 0};
    tbl[2] = '{4'b0000, 1,   {10'd468, {3{10'd1023}}},                4'b1000, 0, 0, 0};
    tbl[3] = '{4'b0000, 29,  {10'd410, 10'd470, {2{10'd1023}}},       4'b1100, 0, 0, 0};
    tbl[4] = '{4'b0000, 175, {10'd60,  10'd120, 10'd180, 10'd240},    4'b1111, 0, 0, 0};
    tbl[5] = '{4'b1000, 1,   {10'd58,  10'd118, 10'd178, 10'd238},    4'b1111, 0, 0, 0};
    tbl[6] = '{4'b0000, 7,   {10'd44,  10'd104, 10'd164, 10'd224},    4'b1111, 0, 0, 0};
    tbl[7] = '{4'b1000, 1,   {10'd1023, 10'd102, 10'd162, 10'd222},   4'b0111, 1, 1, 0};
    tbl[8] = '{4'b0000, 35,  {10'd452, 10'd32,  10'd92,  10'd152},    4'b1111, 1, 0, 0};
    tbl[9] = '{4'b0000, 1,   {10'd450, 10'd1023, 10'd90, 10'd150},    4'b1011, 1, 0, 1};

    repeat (3) step();
    rst_ni = 1'b1;
    model_reset();
    step();
    chk("rst_y",      arrow_y_o,      {4{10'd1023}});
    chk("rst_act",    arrow_active_o, 4'b0000);
    chk("rst_score",  score_o,        8'd0);
    chk("rst_busy",   busy_o,         1'b0);
    chk("rst_hit",    hit_o,          1'b0);
    chk("rst_miss",   miss_o,         1'b0);

    // Directed frame table: spawn, scroll, early press, hit at 44, miss at 32.
    for (int e = 0; e < 10; e++) begin
      int h0, m0;
      h0 = hit_cnt;
      m0 = miss_cnt;
      for (int k = 0; k < tbl[e].frames; k++) do_frame(tbl[e].btn, 1'b1);
      chk($sformatf("tbl%0d_y", e),     arrow_y_o,         tbl[e].exp_y);
      chk($sformatf("tbl%0d_act", e),   arrow_active_o,    tbl[e].exp_act);
      chk($sformatf("tbl%0d_score", e), score_o,           tbl[e].exp_score);
      chk($sformatf("tbl%0d_hits", e),  hit_cnt - h0,      tbl[e].exp_hits);
      chk($sformatf("tbl%0d_miss", e),  miss_cnt - m0,     tbl[e].exp_miss);
    end

    // frame_i during an update must not restart or extend the frame.
    btn_i = 4'b0000; run_i = 1'b1; frame_i = 1'b1;
    step();
    frame_i = 1'b0;
    chk("busy_c1", busy_o, 1'b1);
    frame_i = 1'b1;
    step();
    frame_i = 1'b0;
    repeat (3) step();
    chk("busy_c5", busy_o, 1'b1);
    step();
    chk("busy_c6", busy_o, 1'b0);
    step(); step();
    chk("busy_c8", busy_o, 1'b0);
    model_frame(4'b0000);
    check_model("busy_seq");

    // Asynchronous reset in cycle 3 of an update.
    frame_i = 1'b1;
    step();
    frame_i = 1'b0;
    step(); step();
    rst_ni = 1'b0;
    #1;
    chk("midrst_y",     arrow_y_o,      {4{10'd1023}});
    chk("midrst_act",   arrow_active_o, 4'b0000);
    chk("midrst_score", score_o,        8'd0);
    chk("midrst_busy",  busy_o,         1'b0);
    chk("midrst_hit",   hit_o,          1'b0);
    chk("midrst_miss",  miss_o,         1'b0);
    step(); step();
    rst_ni = 1'b1;
    model_reset();
    step();
    check_model("post_rst");

    // Random presses and run gating against the frame model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] b;
      logic       r;
      int h0, m0, hs0, ms0, mh0, mm0;
      b   = 4'($urandom);
      r   = ($urandom_range(0, 7) != 0);
      h0  = hit_cnt;  m0  = miss_cnt;
      hs0 = hit_cnt_s; ms0 = miss_cnt_s;
      mh0 = m_hits;   mm0 = m_misses;
      do_frame(b, r);
      chk($sformatf("rnd%0d_hits", i),  hit_cnt - h0,    m_hits - mh0);
      chk($sformatf("rnd%0d_miss", i),  miss_cnt - m0,   m_misses - mm0);
      chk($sformatf("rnd%0d_hits4", i), hit_cnt_s - hs0, m_hits - mh0);
      chk($sformatf("rnd%0d_miss4", i), miss_cnt_s - ms0, m_misses - mm0);
      check_model($sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_busy4", i), busy_s, 1'b0);
      chk($sformatf("rnd%0d_act4", i),  act_s,  m_actv());
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
